// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: funct3 access codes, FSM encoding
// and the alignment rule used by both the FSM and the WB fault flag.
package mem_stage_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // funct3[1:0] carries the access size for both loads and stores.
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] lane);
        case (funct3[1:0])
            2'b01:   return lane[0];
            2'b10:   return |lane;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Combinational load extractor: picks the addressed byte/half out of the
// bus word and sign- or zero-extends it to 32 bits.
module load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  lane,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = 8'(rdata >> {lane, 3'b000});
        half_sel = lane[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   data = {24'd0, byte_sel};
            F3_H:    data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   data = {16'd0, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM stage with MEM/WB pipeline register: issues loads/stores on a req/ack
// bus, stalls EX/MEM while busy, and flags misalignment and bus timeouts.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        valid_MEM_I,
    input  logic        MemRead_MEM_I,
    input  logic        MemWrite_MEM_I,
    input  logic [2:0]  funct3_MEM_I,
    input  logic [31:0] ALU_result_MEM_I,
    input  logic [31:0] rs2_data_MEM_I,
    input  logic        MemtoReg_MEM_I,
    input  logic        jal_MEM_I,
    input  logic        jalr_MEM_I,
    input  logic        lui_MEM_I,
    input  logic        U_type_MEM_I,
    input  logic        RegWrite_MEM_I,
    input  logic [4:0]  rd_MEM_I,
    input  logic [31:0] pc_jump_MEM_I,
    input  logic [31:0] imme_MEM_I,
    input  logic [31:0] pc_order_MEM_I,

    output logic        mem_stall_O,

    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,

    output logic        valid_WB_O,
    output logic        RegWrite_WB_O,
    output logic [4:0]  rd_WB_O,
    output logic        MemtoReg_WB_O,
    output logic        jal_WB_O,
    output logic        jalr_WB_O,
    output logic        lui_WB_O,
    output logic        U_type_WB_O,
    output logic [31:0] ALU_result_WB_O,
    output logic [31:0] loaddata_WB_O,
    output logic [31:0] pc_jump_WB_O,
    output logic [31:0] imme_WB_O,
    output logic [31:0] pc_order_WB_O,
    output logic        misalign_WB_O,
    output logic        bus_err_WB_O
);

    localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);

    state_t      state, state_nxt;
    logic [31:0] tcnt;

    logic        is_mem;
    logic        misalign;
    logic        aligned_mem;
    logic        timeout;
    logic        done;
    logic        bus_fault;
    logic        retire;
    logic [31:0] st_wdata;
    logic [3:0]  st_be;
    logic [31:0] load_val;

    assign is_mem      = valid_MEM_I & (MemRead_MEM_I | MemWrite_MEM_I);
    assign misalign    = is_mem & is_misaligned(funct3_MEM_I, ALU_result_MEM_I[1:0]);
    assign aligned_mem = is_mem & ~misalign;
    assign timeout     = (TIMEOUT != 0) && (tcnt == TO_LAST);

    // Ack has priority over timeout: a timeout only counts as a fault without ack.
    assign done        = (state == BUSY) & (dmem_ack | timeout);
    assign bus_fault   = (state == BUSY) & ~dmem_ack & timeout;
    assign retire      = ((state == IDLE) & ~aligned_mem) | done;
    assign mem_stall_O = aligned_mem & ~done;

    load_align u_load_align (
        .rdata  (dmem_rdata),
        .lane   (ALU_result_MEM_I[1:0]),
        .funct3 (funct3_MEM_I),
        .data   (load_val)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (aligned_mem) state_nxt = BUSY;
            BUSY: if (done)        state_nxt = IDLE;
        endcase
    end

    // Store lane formatting; loads request the whole word.
    always_comb begin
        st_wdata = MemWrite_MEM_I ? rs2_data_MEM_I : 32'd0;
        st_be    = 4'b1111;
        if (MemWrite_MEM_I) begin
            case (funct3_MEM_I[1:0])
                2'b00: begin
                    st_wdata = {4{rs2_data_MEM_I[7:0]}};
                    st_be    = 4'b0001 << ALU_result_MEM_I[1:0];
                end
                2'b01: begin
                    st_wdata = {2{rs2_data_MEM_I[15:0]}};
                    st_be    = 4'b0011 << {ALU_result_MEM_I[1], 1'b0};
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            tcnt       <= 32'd0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= 32'd0;
            dmem_wdata <= 32'd0;
            dmem_be    <= 4'd0;
        end else begin
            state <= state_nxt;
            if (state == IDLE) begin
                tcnt <= 32'd0;
                if (aligned_mem) begin
                    dmem_req   <= 1'b1;
                    dmem_we    <= MemWrite_MEM_I;
                    dmem_addr  <= {ALU_result_MEM_I[31:2], 2'b00};
                    dmem_wdata <= st_wdata;
                    dmem_be    <= st_be;
                end
            end else begin
                tcnt <= tcnt + 32'd1;
                if (done) begin
                    dmem_req <= 1'b0;
                    dmem_we  <= 1'b0;
                end
            end
        end
    end

    // MEM/WB register: inserts a bubble on every cycle that does not retire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_WB_O      <= 1'b0;
            RegWrite_WB_O   <= 1'b0;
            rd_WB_O         <= 5'd0;
            MemtoReg_WB_O   <= 1'b0;
            jal_WB_O        <= 1'b0;
            jalr_WB_O       <= 1'b0;
            lui_WB_O        <= 1'b0;
            U_type_WB_O     <= 1'b0;
            ALU_result_WB_O <= 32'd0;
            loaddata_WB_O   <= 32'd0;
            pc_jump_WB_O    <= 32'd0;
            imme_WB_O       <= 32'd0;
            pc_order_WB_O   <= 32'd0;
            misalign_WB_O   <= 1'b0;
            bus_err_WB_O    <= 1'b0;
        end else if (retire) begin
            valid_WB_O      <= valid_MEM_I;
            RegWrite_WB_O   <= valid_MEM_I & RegWrite_MEM_I & ~misalign & ~bus_fault;
            rd_WB_O         <= rd_MEM_I;
            MemtoReg_WB_O   <= MemtoReg_MEM_I;
            jal_WB_O        <= jal_MEM_I;
            jalr_WB_O       <= jalr_MEM_I;
            lui_WB_O        <= lui_MEM_I;
            U_type_WB_O     <= U_type_MEM_I;
            ALU_result_WB_O <= ALU_result_MEM_I;
            loaddata_WB_O   <= (done & dmem_ack & MemRead_MEM_I) ? load_val : 32'd0;
            pc_jump_WB_O    <= pc_jump_MEM_I;
            imme_WB_O       <= imme_MEM_I;
            pc_order_WB_O   <= pc_order_MEM_I;
            misalign_WB_O   <= misalign;
            bus_err_WB_O    <= bus_fault;
        end else begin
            valid_WB_O      <= 1'b0;
            RegWrite_WB_O   <= 1'b0;
            misalign_WB_O   <= 1'b0;
            bus_err_WB_O    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage (TIMEOUT=4) with a simple single-beat bus responder.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_MEM_I, MemRead_MEM_I, MemWrite_MEM_I;
    logic [2:0]  funct3_MEM_I;
    logic [31:0] ALU_result_MEM_I, rs2_data_MEM_I;
    logic        MemtoReg_MEM_I, jal_MEM_I, jalr_MEM_I, lui_MEM_I, U_type_MEM_I, RegWrite_MEM_I;
    logic [4:0]  rd_MEM_I;
    logic [31:0] pc_jump_MEM_I, imme_MEM_I, pc_order_MEM_I;
    logic        mem_stall_O;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        valid_WB_O, RegWrite_WB_O, MemtoReg_WB_O, jal_WB_O, jalr_WB_O, lui_WB_O, U_type_WB_O;
    logic [4:0]  rd_WB_O;
    logic [31:0] ALU_result_WB_O, loaddata_WB_O, pc_jump_WB_O, imme_WB_O, pc_order_WB_O;
    logic        misalign_WB_O, bus_err_WB_O;

    int n_checks = 0;
    int n_errors = 0;

    int          r_stalls, r_lat, r_busy;
    logic        r_done, r_we;
    logic [31:0] r_addr, r_wdata;
    logic [3:0]  r_be;

    mem_stage #(.TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .valid_MEM_I(valid_MEM_I), .MemRead_MEM_I(MemRead_MEM_I), .MemWrite_MEM_I(MemWrite_MEM_I),
        .funct3_MEM_I(funct3_MEM_I), .ALU_result_MEM_I(ALU_result_MEM_I), .rs2_data_MEM_I(rs2_data_MEM_I),
        .MemtoReg_MEM_I(MemtoReg_MEM_I), .jal_MEM_I(jal_MEM_I), .jalr_MEM_I(jalr_MEM_I),
        .lui_MEM_I(lui_MEM_I), .U_type_MEM_I(U_type_MEM_I), .RegWrite_MEM_I(RegWrite_MEM_I),
        .rd_MEM_I(rd_MEM_I), .pc_jump_MEM_I(pc_jump_MEM_I), .imme_MEM_I(imme_MEM_I),
        .pc_order_MEM_I(pc_order_MEM_I),
        .mem_stall_O(mem_stall_O),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_be(dmem_be), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .valid_WB_O(valid_WB_O), .RegWrite_WB_O(RegWrite_WB_O), .rd_WB_O(rd_WB_O),
        .MemtoReg_WB_O(MemtoReg_WB_O), .jal_WB_O(jal_WB_O), .jalr_WB_O(jalr_WB_O),
        .lui_WB_O(lui_WB_O), .U_type_WB_O(U_type_WB_O), .ALU_result_WB_O(ALU_result_WB_O),
        .loaddata_WB_O(loaddata_WB_O), .pc_jump_WB_O(pc_jump_WB_O), .imme_WB_O(imme_WB_O),
        .pc_order_WB_O(pc_order_WB_O), .misalign_WB_O(misalign_WB_O), .bus_err_WB_O(bus_err_WB_O)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction, answer the bus with ack in BUSY cycle ack_at
    // (0 = never), and run until it retires into MEM/WB or 20 cycles pass.
    task automatic run_op(input logic rd_op, input logic wr_op, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input int ack_at, input logic [31:0] rdata);
        valid_MEM_I      = 1'b1;
        MemRead_MEM_I    = rd_op;
        MemWrite_MEM_I   = wr_op;
        funct3_MEM_I     = f3;
        ALU_result_MEM_I = addr;
        rs2_data_MEM_I   = wdata;
        r_stalls = 0; r_lat = 0; r_busy = 0; r_done = 1'b0;
        r_we = 1'b0; r_addr = 32'd0; r_wdata = 32'd0; r_be = 4'd0;
        for (int c = 0; c < 20 && !r_done; c++) begin
            if (dmem_req) begin
                r_busy++;
                if (r_busy == 1) begin
                    r_we = dmem_we; r_addr = dmem_addr; r_wdata = dmem_wdata; r_be = dmem_be;
                end
            end
            dmem_ack   = dmem_req && (r_busy == ack_at);
            dmem_rdata = dmem_ack ? rdata : 32'hDEAD_BEEF;
            #1;
            if (mem_stall_O) r_stalls++;
            @(posedge clk);
            #1;
            r_lat++;
            dmem_ack = 1'b0;
            if (valid_WB_O) r_done = 1'b1;
        end
        valid_MEM_I    = 1'b0;
        MemRead_MEM_I  = 1'b0;
        MemWrite_MEM_I = 1'b0;
        check("retired", 32'(r_done), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not end, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        valid_MEM_I = 0; MemRead_MEM_I = 0; MemWrite_MEM_I = 0; funct3_MEM_I = 3'd0;
        ALU_result_MEM_I = 0; rs2_data_MEM_I = 0; MemtoReg_MEM_I = 0; jal_MEM_I = 0;
        jalr_MEM_I = 0; lui_MEM_I = 0; U_type_MEM_I = 0; RegWrite_MEM_I = 1'b1;
        rd_MEM_I = 5'd7; pc_jump_MEM_I = 32'h0000_4000; imme_MEM_I = 32'hCAFE_0000;
        pc_order_MEM_I = 32'h0000_0104; dmem_ack = 0; dmem_rdata = 0;

        repeat (2) @(posedge clk);
        #1;
        check("rst valid_WB", 32'(valid_WB_O), 32'd0);
        check("rst dmem_req", 32'(dmem_req), 32'd0);
        check("rst ALU_result_WB", ALU_result_WB_O, 32'd0);
        check("rst stall", 32'(mem_stall_O), 32'd0);
        rst_n = 1'b1;
        step();

        // Non-memory op
        run_op(1'b0, 1'b0, 3'b000, 32'h0000_1234, 32'd0, 0, 32'd0);
        check("alu lat", 32'(r_lat), 32'd1);
        check("alu stalls", 32'(r_stalls), 32'd0);
        check("alu busy", 32'(r_busy), 32'd0);
        check("alu result", ALU_result_WB_O, 32'h0000_1234);
        check("alu regwrite", 32'(RegWrite_WB_O), 32'd1);
        check("alu rd", 32'(rd_WB_O), 32'd7);
        check("alu imme", imme_WB_O, 32'hCAFE_0000);
        step();
        check("bubble valid", 32'(valid_WB_O), 32'd0);

        // LB with ack in the 4th BUSY cycle (also the timeout cycle: ack wins)
        run_op(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'd0, 4, 32'h80FF_FF12);
        check("lb addr", r_addr, 32'h0000_0100);
        check("lb we", 32'(r_we), 32'd0);
        check("lb be", 32'(r_be), 32'hF);
        check("lb stalls", 32'(r_stalls), 32'd4);
        check("lb lat", 32'(r_lat), 32'd5);
        check("lb data", loaddata_WB_O, 32'hFFFF_FF80);
        check("lb bus_err", 32'(bus_err_WB_O), 32'd0);
        check("lb regwrite", 32'(RegWrite_WB_O), 32'd1);
        check("lb req dropped", 32'(dmem_req), 32'd0);

        // SH with immediate ack
        run_op(1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'h0000_ABCD, 1, 32'd0);
        check("sh be", 32'(r_be), 32'hC);
        check("sh wdata", r_wdata, 32'hABCD_ABCD);
        check("sh we", 32'(r_we), 32'd1);
        check("sh addr", r_addr, 32'h0000_0200);
        check("sh lat", 32'(r_lat), 32'd2);

        // SB lane 1
        run_op(1'b0, 1'b1, 3'b000, 32'h0000_0501, 32'h0000_00AB, 1, 32'd0);
        check("sb be", 32'(r_be), 32'h2);
        check("sb wdata", r_wdata, 32'hABAB_ABAB);

        // SW
        run_op(1'b0, 1'b1, 3'b010, 32'h0000_0600, 32'h1234_5678, 2, 32'd0);
        check("sw be", 32'(r_be), 32'hF);
        check("sw wdata", r_wdata, 32'h1234_5678);
        check("sw lat", 32'(r_lat), 32'd3);

        // Extension variants
        run_op(1'b1, 1'b0, 3'b100, 32'h0000_0101, 32'd0, 2, 32'h1234_80FF);
        check("lbu data", loaddata_WB_O, 32'h0000_0080);
        run_op(1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'd0, 1, 32'h8001_0000);
        check("lh data", loaddata_WB_O, 32'hFFFF_8001);
        run_op(1'b1, 1'b0, 3'b101, 32'h0000_0102, 32'd0, 1, 32'h8001_0000);
        check("lhu data", loaddata_WB_O, 32'h0000_8001);
        run_op(1'b1, 1'b0, 3'b010, 32'h0000_0104, 32'd0, 1, 32'hA5A5_0F0F);
        check("lw data", loaddata_WB_O, 32'hA5A5_0F0F);

        // Misaligned LW
        run_op(1'b1, 1'b0, 3'b010, 32'h0000_0301, 32'd0, 1, 32'd0);
        check("mis busy", 32'(r_busy), 32'd0);
        check("mis lat", 32'(r_lat), 32'd1);
        check("mis flag", 32'(misalign_WB_O), 32'd1);
        check("mis regwrite", 32'(RegWrite_WB_O), 32'd0);

        // Timeout
        run_op(1'b1, 1'b0, 3'b010, 32'h0000_0400, 32'd0, 0, 32'd0);
        check("to busy", 32'(r_busy), 32'd4);
        check("to stalls", 32'(r_stalls), 32'd4);
        check("to bus_err", 32'(bus_err_WB_O), 32'd1);
        check("to regwrite", 32'(RegWrite_WB_O), 32'd0);
        check("to req dropped", 32'(dmem_req), 32'd0);

        // Stray ack while idle
        dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
        step();
        dmem_ack = 1'b0;
        check("stray valid", 32'(valid_WB_O), 32'd0);
        check("stray req", 32'(dmem_req), 32'd0);

        // Reset while BUSY
        valid_MEM_I = 1'b1; MemRead_MEM_I = 1'b1; funct3_MEM_I = 3'b010;
        ALU_result_MEM_I = 32'h0000_0700;
        step();
        check("rb req", 32'(dmem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rb req async", 32'(dmem_req), 32'd0);
        check("rb valid async", 32'(valid_WB_O), 32'd0);
        valid_MEM_I = 1'b0; MemRead_MEM_I = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        dmem_ack = 1'b1; dmem_rdata = 32'h1111_2222;
        step();
        dmem_ack = 1'b0;
        check("rb late ack valid", 32'(valid_WB_O), 32'd0);
        check("rb late ack data", loaddata_WB_O, 32'd0);
        check("rb late ack req", 32'(dmem_req), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
